// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: ownership states and port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_CPU,
        OWN_DMA
    } state_t;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DMA = 1;

endpackage

// File: rtl/dmem_arbiter.sv
// Burst-limited round-robin arbiter sharing one single-ported data memory
// between the CPU MEM stage and a DMA/loader port. Grants are combinational,
// read data returns registered one cycle after the grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] run_cnt, run_nxt;
    logic [1:0]       gnt;

    // Ownership state and consecutive-grant counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
        end
    end

    // Grant selection, owner/run update and memory-side mux.
    always_comb begin
        gnt       = '0;
        state_nxt = state;
        run_nxt   = run_cnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Grants are held off while reset is asserted.
        if (!reset) begin
            if (cpu_req && dma_req) begin
                case (state)
                    OWN_CPU: begin
                        if (run_cnt < CNT_MAX) gnt[PORT_CPU] = 1'b1;
                        else                   gnt[PORT_DMA] = 1'b1;
                    end
                    OWN_DMA: begin
                        if (run_cnt < CNT_MAX) gnt[PORT_DMA] = 1'b1;
                        else                   gnt[PORT_CPU] = 1'b1;
                    end
                    default: gnt[PORT_CPU] = 1'b1;
                endcase
            end else begin
                gnt[PORT_CPU] = cpu_req;
                gnt[PORT_DMA] = dma_req;
            end
        end

        if (gnt == '0) begin
            state_nxt = IDLE;
            run_nxt   = '0;
        end else if (gnt[PORT_CPU]) begin
            if (state == OWN_CPU) begin
                if (run_cnt != CNT_MAX) run_nxt = run_cnt + CNT_W'(1);
            end else begin
                state_nxt = OWN_CPU;
                run_nxt   = CNT_W'(1);
            end
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            if (state == OWN_DMA) begin
                if (run_cnt != CNT_MAX) run_nxt = run_cnt + CNT_W'(1);
            end else begin
                state_nxt = OWN_DMA;
                run_nxt   = CNT_W'(1);
            end
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt   = gnt[PORT_CPU];
    assign dma_gnt   = gnt[PORT_DMA];
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // CPU read-return slice: capture memory data on a granted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
        end
    end

    // DMA read-return slice: capture memory data on a granted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural arbitration/memory
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned MAXB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter, word-indexed, combinational read.
    logic [31:0] ram [256];
    logic [31:0] shadow [256];
    assign mem_rdata = ram[mem_addr[9:2]];

    always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner 0 = none, 1 = CPU, 2 = DMA.
    int          m_owner = 0;
    int          m_run = 0;
    bit          m_ok = 1'b0;
    bit          m_cvld = 1'b0, m_dvld = 1'b0;
    logic [31:0] m_crd = '0, m_drd = '0;

    // Per-cycle compare against the model, then advance the model across the edge.
    always @(negedge clk) begin
        bit gc, gd, exp_we;
        int g;
        logic [31:0] exp_addr, exp_wdata;
        gc = 1'b0;
        gd = 1'b0;
        if (!reset) begin
            if (cpu_req && dma_req) begin
                // Stay with the owner until its run hits the burst limit, else hand over.
                if (m_owner == 2) gd = (m_run < MAXB);
                else if (m_owner == 1) gd = (m_run >= MAXB);
                gc = !gd;
            end else begin
                gc = cpu_req;
                gd = dma_req;
            end
        end
        exp_we = gc ? cpu_we : (gd ? dma_we : 1'b0);
        exp_addr = gc ? cpu_addr : (gd ? dma_addr : 32'h0);
        exp_wdata = gc ? cpu_wdata : (gd ? dma_wdata : 32'h0);
        if (m_ok) begin
            check("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, gc});
            check("dma_gnt", {31'b0, dma_gnt}, {31'b0, gd});
            check("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !gc});
            check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, exp_wdata);
            check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_cvld});
            check("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_dvld});
            check("cpu_rdata", cpu_rdata, m_crd);
            check("dma_rdata", dma_rdata, m_drd);
        end
        if (reset) begin
            m_owner = 0; m_run = 0; m_cvld = 0; m_dvld = 0;
            m_crd = '0; m_drd = '0; m_ok = 1'b1;
        end else begin
            m_cvld = gc && !cpu_we;
            m_dvld = gd && !dma_we;
            if (m_cvld) m_crd = shadow[cpu_addr[9:2]];
            if (m_dvld) m_drd = shadow[dma_addr[9:2]];
            if (gc && cpu_we) shadow[cpu_addr[9:2]] = cpu_wdata;
            if (gd && dma_we) shadow[dma_addr[9:2]] = dma_wdata;
            g = gc ? 1 : (gd ? 2 : 0);
            if (g == 0) begin m_owner = 0; m_run = 0; end
            else if (g == m_owner) m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
            else begin m_owner = g; m_run = 1; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'hA500_0000 + 32'(i);
            shadow[i] = 32'hA500_0000 + 32'(i);
        end
        ram[4] = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;

        // Reset: grants held off, stall follows cpu_req.
        reset = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dma(1'b1, 1'b0, 32'h14, 32'h0);
        tick(); settle();
        check("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
        check("rst_dma_gnt", {31'b0, dma_gnt}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h1);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        tick(); settle();
        check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);

        // CPU read of word 4.
        tick();
        reset = 1'b0;
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t1_gnt", {31'b0, cpu_gnt}, 32'h1);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t1_rvalid", {31'b0, cpu_rvalid}, 32'h1);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_dma_rvalid", {31'b0, dma_rvalid}, 32'h0);

        // Simultaneous from IDLE: CPU write wins, DMA reads the new value.
        tick();
        set_cpu(1'b1, 1'b1, 32'h20, 32'h1234);
        set_dma(1'b1, 1'b0, 32'h20, 32'h0);
        settle();
        check("t2_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        check("t2_dma_gnt", {31'b0, dma_gnt}, 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t2_dma_gnt2", {31'b0, dma_gnt}, 32'h1);
        check("t2_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        tick();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t2_dma_rvalid", {31'b0, dma_rvalid}, 32'h1);
        check("t2_dma_rdata", dma_rdata, 32'h1234);

        // DMA from cycle 0, CPU from cycle 1: DMA x4 then CPU.
        tick();
        for (int i = 0; i < 5; i++) begin
            set_dma(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
            if (i >= 1) set_cpu(1'b1, 1'b0, 32'h80, 32'h0);
            settle();
            check("t3_dma_gnt", {31'b0, dma_gnt}, (i < 4) ? 32'h1 : 32'h0);
            check("t3_cpu_gnt", {31'b0, cpu_gnt}, (i == 4) ? 32'h1 : 32'h0);
            check("t3_stall", {31'b0, cpu_stall}, (i >= 1 && i < 4) ? 32'h1 : 32'h0);
            tick();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Both hold requests for 12 cycles from IDLE: CPU x4, DMA x4, CPU x4.
        for (int i = 0; i < 12; i++) begin
            set_cpu(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
            set_dma(1'b1, (i % 3) == 0, 32'h200 + 32'(4 * i), 32'h5500 + 32'(i));
            settle();
            check("t4_cpu_gnt", {31'b0, cpu_gnt}, (i < 4 || i >= 8) ? 32'h1 : 32'h0);
            check("t4_dma_gnt", {31'b0, dma_gnt}, (i >= 4 && i < 8) ? 32'h1 : 32'h0);
            tick();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset during a DMA burst read: rvalid suppressed, ownership cleared.
        set_dma(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        settle();
        check("t5_dma_gnt_rst", {31'b0, dma_gnt}, 32'h0);
        tick();
        reset = 1'b0;
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t5_dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
        tick();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dma(1'b1, 1'b0, 32'h14, 32'h0);
        settle();
        check("t5_cpu_first", {31'b0, cpu_gnt}, 32'h1);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // DMA burst, idle gap, new DMA run gets a fresh 4-grant allowance.
        for (int i = 0; i < 4; i++) begin
            set_dma(1'b1, 1'b0, 32'h60, 32'h0);
            tick();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_dma(1'b1, 1'b0, 32'h64, 32'h0);
            if (i >= 1) set_cpu(1'b1, 1'b1, 32'h68, 32'hCAFE);
            settle();
            check("t6_dma_gnt", {31'b0, dma_gnt}, (i < 4) ? 32'h1 : 32'h0);
            check("t6_cpu_gnt", {31'b0, cpu_gnt}, (i == 4) ? 32'h1 : 32'h0);
            tick();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_dma(1'b1, 1'b0, 32'h68, 32'h0);
        tick();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t6_readback", dma_rdata, 32'hCAFE);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
